// File: rtl/data_read_axi_regs_wr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_read_axi_regs_wr_pkg
//  Purpose  : Shared constants, FSM encoding and helpers for the data_read
//             AXI4-Lite register write slave.
//  Revision : 1.0 - initial parametrised write slave
// ============================================================================
package data_read_axi_regs_wr_pkg;

   localparam int REG_WIDTH  = 32;
   localparam int STRB_WIDTH = REG_WIDTH / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Register word offsets
   localparam int AXI_ADDR_CR = 0;

   // Handshake FSM: which halves of the write are currently held
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HOLD_A = 3'd1,
      ST_HOLD_D = 3'd2,
      ST_COMMIT = 3'd3,
      ST_RESP   = 3'd4
   } wr_state_e;

   // Expand byte enables into a per-bit mask
   function automatic logic [REG_WIDTH-1:0] strb_to_mask(input logic [STRB_WIDTH-1:0] strb);
      logic [REG_WIDTH-1:0] mask;
      for (int b = 0; b < STRB_WIDTH; b++) begin
         mask[b*8 +: 8] = {8{strb[b]}};
      end
      return mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_read_axi_regs_wr_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_read_axi_regs_wr_if
//  Purpose  : AXI4-Lite write-channel bundle (AW, W, B) with master/slave views.
//  Revision : 1.0 - initial parametrised write slave
// ============================================================================
interface data_read_axi_regs_wr_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface
`default_nettype wire

// File: rtl/data_read_axi_regs_wr_reg_word.sv
`default_nettype none
// ============================================================================
//  Module   : data_read_axi_regs_wr_reg_word
//  Purpose  : One 32-bit control register with byte-enable write, reset value
//             and self-clearing (pulse) bits.
//  Revision : 1.0 - initial parametrised write slave
// ============================================================================
module data_read_axi_regs_wr_reg_word
   import data_read_axi_regs_wr_pkg::*;
#(
   parameter logic [REG_WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [REG_WIDTH-1:0] PULSE_MASK  = '0
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  we,
   input  wire logic [REG_WIDTH-1:0]  wdata,
   input  wire logic [STRB_WIDTH-1:0] wstrb,
   output logic      [REG_WIDTH-1:0]  value_o
);

   logic [REG_WIDTH-1:0] value_d, value_q;
   logic [REG_WIDTH-1:0] byte_mask, held;

   // Pulse bits drop every cycle; a write merges enabled bytes over the held value
   always_comb begin
      byte_mask = strb_to_mask(wstrb);
      held      = value_q & ~PULSE_MASK;
      value_d   = held;
      if (we) begin
         value_d = (held & ~byte_mask) | (wdata & byte_mask);
      end
   end

   // Register storage
   always_ff @(posedge clk) begin
      if (rst) value_q <= RESET_VALUE;
      else     value_q <= value_d;
   end

   assign value_o = value_q;

endmodule
`default_nettype wire

// File: rtl/data_read_axi_regs_wr.sv
`default_nettype none
// ============================================================================
//  Module   : data_read_axi_regs_wr
//  Purpose  : AXI4-Lite write slave for the data_read core: independent AW/W
//             capture, WSTRB byte writes into a register bank, pulse bits,
//             SLVERR for unmapped addresses, one outstanding write.
//  Revision : 1.0 - initial parametrised write slave
// ============================================================================
module data_read_axi_regs_wr
   import data_read_axi_regs_wr_pkg::*;
#(
   parameter int                                   C_ADDR_WIDTH  = 32,
   parameter int                                   C_DATA_WIDTH  = 32,
   parameter int                                   C_NUM_REGS    = 4,
   parameter logic [C_ADDR_WIDTH-1:0]              C_BASEADDR    = '0,
   parameter logic [C_NUM_REGS*C_DATA_WIDTH-1:0]   C_RESET_VALUE = '0,
   parameter logic [C_NUM_REGS*C_DATA_WIDTH-1:0]   C_PULSE_MASK  =
      {{(C_NUM_REGS*C_DATA_WIDTH-1){1'b0}}, 1'b1}
) (
   input  wire logic                              S_AXI_ACLK,
   input  wire logic                              S_AXI_ARESET,
   data_read_axi_regs_wr_if.slave                 s_axi,
   output logic [C_NUM_REGS*C_DATA_WIDTH-1:0]     regs_o,
   output logic [C_NUM_REGS-1:0]                  wr_stb_o
);

   localparam int IDX_W = C_ADDR_WIDTH - 2;

   wr_state_e                 state_d, state_q;
   logic [C_ADDR_WIDTH-1:0]   awaddr_d, awaddr_q;
   logic [C_DATA_WIDTH-1:0]   wdata_d, wdata_q;
   logic [C_DATA_WIDTH/8-1:0] wstrb_d, wstrb_q;
   logic [1:0]                bresp_d, bresp_q;
   logic [C_NUM_REGS-1:0]     wr_stb_d, wr_stb_q;

   logic                      awready, wready, aw_hs, w_hs;
   logic [IDX_W-1:0]          idx;
   logic                      addr_ok;
   logic [C_NUM_REGS-1:0]     reg_we;

   // Readies depend only on held state (never on VALID), and stay low in reset
   assign awready = !S_AXI_ARESET && (state_q == ST_IDLE || state_q == ST_HOLD_D);
   assign wready  = !S_AXI_ARESET && (state_q == ST_IDLE || state_q == ST_HOLD_A);
   assign aw_hs   = s_axi.awvalid && awready;
   assign w_hs    = s_axi.wvalid  && wready;

   // Word index relative to the base; byte lane bits are dropped by the shift
   assign idx     = IDX_W'((awaddr_q - C_BASEADDR) >> 2);
   assign addr_ok = (awaddr_q >= C_BASEADDR) && (idx < IDX_W'(C_NUM_REGS));

   // Next-state, capture and response logic
   always_comb begin
      state_d  = state_q;
      awaddr_d = awaddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      bresp_d  = bresp_q;
      wr_stb_d = '0;
      if (aw_hs) awaddr_d = s_axi.awaddr;
      if (w_hs) begin
         wdata_d = s_axi.wdata;
         wstrb_d = s_axi.wstrb;
      end
      case (state_q)
         ST_IDLE: begin
            if (aw_hs && w_hs) state_d = ST_COMMIT;
            else if (aw_hs)    state_d = ST_HOLD_A;
            else if (w_hs)     state_d = ST_HOLD_D;
         end
         ST_HOLD_A: if (w_hs)  state_d = ST_COMMIT;
         ST_HOLD_D: if (aw_hs) state_d = ST_COMMIT;
         ST_COMMIT: begin
            state_d  = ST_RESP;
            bresp_d  = addr_ok ? RESP_OKAY : RESP_SLVERR;
            wr_stb_d = reg_we;
         end
         ST_RESP:   if (s_axi.bready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State and capture registers; reset drops any partial transaction
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         state_q  <= ST_IDLE;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bresp_q  <= RESP_OKAY;
         wr_stb_q <= '0;
      end else begin
         state_q  <= state_d;
         awaddr_q <= awaddr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         bresp_q  <= bresp_d;
         wr_stb_q <= wr_stb_d;
      end
   end

   generate
      for (genvar gi = 0; gi < C_NUM_REGS; gi++) begin : g_regs
         assign reg_we[gi] = (state_q == ST_COMMIT) && addr_ok && (idx == IDX_W'(gi));

         data_read_axi_regs_wr_reg_word #(
            .RESET_VALUE (C_RESET_VALUE[gi*C_DATA_WIDTH +: C_DATA_WIDTH]),
            .PULSE_MASK  (C_PULSE_MASK [gi*C_DATA_WIDTH +: C_DATA_WIDTH])
         ) u_reg (
            .clk     (S_AXI_ACLK),
            .rst     (S_AXI_ARESET),
            .we      (reg_we[gi]),
            .wdata   (wdata_q),
            .wstrb   (wstrb_q),
            .value_o (regs_o[gi*C_DATA_WIDTH +: C_DATA_WIDTH])
         );
      end
   endgenerate

   assign s_axi.awready = awready;
   assign s_axi.wready  = wready;
   assign s_axi.bvalid  = (state_q == ST_RESP);
   assign s_axi.bresp   = bresp_q;
   assign wr_stb_o      = wr_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_data_read_axi_regs_wr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_read_axi_regs_wr
//  Purpose  : Self-checking bench for data_read_axi_regs_wr with a byte-level
//             register model and directed plus randomized writes.
//  Revision : 1.0 - initial
// ============================================================================
module tb_data_read_axi_regs_wr;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] regs;
   logic [3:0]   wr_stb;
   int           checks   = 0;
   int           failures = 0;
   int           cyc      = 0;
   int           last_hs  = 0;
   int           prev_hs  = 0;

   logic [31:0]  model [4];

   data_read_axi_regs_wr_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   data_read_axi_regs_wr dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESET (rst),
      .s_axi        (bus),
      .regs_o       (regs),
      .wr_stb_o     (wr_stb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] model_flat();
      return {model[3], model[2], model[1], model[0]};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full write transaction; entered and left at a negedge.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int br_dly);
      bit           aw_done = 0, w_done = 0, aw_hs, w_hs, ok;
      int           n = 0;
      logic [29:0]  widx;
      logic [127:0] exp_old, exp_new, exp_settled;
      logic [3:0]   exp_stb;
      logic [1:0]   exp_resp;

      widx     = addr[31:2];
      ok       = (widx < 30'd4);
      exp_old  = model_flat();
      exp_stb  = 4'b0;
      exp_resp = ok ? 2'b00 : 2'b10;
      if (ok) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[widx[1:0]][b*8 +: 8] = data[b*8 +: 8];
         exp_stb[widx[1:0]] = 1'b1;
      end
      exp_new     = model_flat();
      model[0][0] = 1'b0;            // CR.START self-clears after one cycle
      exp_settled = model_flat();

      bus.bready = (br_dly == 0);
      while (!(aw_done && w_done) && n < 60) begin
         bus.awaddr  = addr;
         bus.awvalid = !aw_done && (n >= aw_dly);
         bus.wdata   = data;
         bus.wstrb   = strb;
         bus.wvalid  = !w_done && (n >= w_dly);
         aw_hs = bus.awvalid && bus.awready;
         w_hs  = bus.wvalid  && bus.wready;
         if (aw_hs || w_hs) last_hs = cyc;
         @(posedge clk);
         aw_done |= aw_hs;
         w_done  |= w_hs;
         n++;
         @(negedge clk);
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      if (!(aw_done && w_done)) begin
         check("handshake_timeout", 128'(aw_done && w_done), 128'd1);
         return;
      end
      // cycle k+1: commit pending, nothing visible yet
      check("bvalid_k1", 128'(bus.bvalid), 128'd0);
      check("regs_k1",   regs, exp_old);
      check("stb_k1",    128'(wr_stb), 128'd0);
      @(negedge clk);
      // cycle k+2: response and new register values
      check("bvalid_k2",  128'(bus.bvalid), 128'd1);
      check("bresp_k2",   128'(bus.bresp), 128'(exp_resp));
      check("regs_k2",    regs, exp_new);
      check("stb_k2",     128'(wr_stb), 128'(exp_stb));
      check("awready_k2", 128'(bus.awready), 128'd0);
      check("wready_k2",  128'(bus.wready), 128'd0);
      for (int i = 0; i < br_dly; i++) begin
         @(negedge clk);
         check("bvalid_hold",  128'(bus.bvalid), 128'd1);
         check("bresp_hold",   128'(bus.bresp), 128'(exp_resp));
         check("awready_hold", 128'(bus.awready), 128'd0);
         check("wready_hold",  128'(bus.wready), 128'd0);
         check("regs_hold",    regs, exp_settled);
         check("stb_hold",     128'(wr_stb), 128'd0);
      end
      bus.bready = 1'b1;
      @(negedge clk);
      check("bvalid_done",  128'(bus.bvalid), 128'd0);
      check("awready_done", 128'(bus.awready), 128'd1);
      check("wready_done",  128'(bus.wready), 128'd1);
      check("regs_settled", regs, exp_settled);
      check("stb_done",     128'(wr_stb), 128'd0);
   endtask

   initial begin
      logic [31:0] a;
      for (int r = 0; r < 4; r++) model[r] = 32'h0;
      rst         = 1'b1;
      bus.awaddr  = '0;
      bus.awvalid = 1'b0;
      bus.wdata   = '0;
      bus.wstrb   = '0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_awready", 128'(bus.awready), 128'd0);
      check("rst_wready",  128'(bus.wready), 128'd0);
      check("rst_bvalid",  128'(bus.bvalid), 128'd0);
      check("rst_bresp",   128'(bus.bresp), 128'd0);
      check("rst_regs",    regs, 128'd0);
      check("rst_stb",     128'(wr_stb), 128'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_awready", 128'(bus.awready), 128'd1);

      // Reset in the middle of a W-only capture discards it
      do_write(32'hC, 32'h1357_9BDF, 4'hF, 0, 0, 0);
      bus.wdata  = 32'hCAFE_F00D;
      bus.wstrb  = 4'hF;
      bus.wvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.wvalid = 1'b0;
      check("w_held_wready", 128'(bus.wready), 128'd0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst_awready", 128'(bus.awready), 128'd0);
         check("midrst_bvalid",  128'(bus.bvalid), 128'd0);
      end
      rst = 1'b0;
      for (int r = 0; r < 4; r++) model[r] = 32'h0;
      check("midrst_regs", regs, 128'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("postrst_bvalid", 128'(bus.bvalid), 128'd0);
      end
      check("postrst_wready", 128'(bus.wready), 128'd1);

      // Directed cases
      do_write(32'h4, 32'hA5A5_1234, 4'hF, 0, 0, 0);
      do_write(32'h8, 32'hFFFF_FFFF, 4'b0101, 3, 0, 0);
      check("reg2_strb", 128'(regs[64 +: 32]), 128'h00FF_00FF);
      do_write(32'h0, 32'hDEAD_BEE0, 4'hF, 0, 1, 0);
      do_write(32'h0, 32'h0000_0001, 4'b0001, 1, 0, 0);
      check("reg0_pulse_clr", 128'(regs[31:0]), 128'hDEAD_BE00);
      do_write(32'h10, 32'h1111_1111, 4'hF, 0, 0, 0);
      do_write(32'h6, 32'h2222_2222, 4'h0, 0, 0, 0);
      do_write(32'hC, 32'h3333_3333, 4'hF, 0, 0, 5);

      // Back-to-back throughput: one write every 3 cycles
      do_write(32'h0, 32'h0000_0100, 4'hF, 0, 0, 0);
      prev_hs = last_hs;
      do_write(32'h4, 32'h0000_0200, 4'hF, 0, 0, 0);
      check("b2b_period", 128'(last_hs - prev_hs), 128'd3);

      // Randomized writes against the model
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 3) != 0)
            a = {28'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         else if ($urandom_range(0, 1) == 1)
            a = (32'($urandom_range(4, 255)) << 2) | 32'($urandom_range(0, 3));
         else
            a = $urandom | 32'h8000_0000;
         do_write(a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
